// File: rtl/wb_uart_tx_pop.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx_pop
// Purpose  : Pops bytes from a TX FIFO over a Wishbone pop bus and shifts
//            each one out as an 8N1 UART frame, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_tx_pop #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fifo_empty,
    output logic          o_wb_pop_stb,
    output logic          o_wb_pop_cyc,
    input  logic          i_wb_pop_stall,
    input  logic          i_wb_pop_ack,
    input  logic [DW-1:0] i_wb_pop_data,
    output logic          o_tx,
    output logic          o_busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] C_CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            r_stb;
    logic            w_stb_nxt;
    logic [CW-1:0]   r_clk_cnt;
    logic [CW-1:0]   w_clk_cnt_nxt;
    logic [BW-1:0]   r_bit_cnt;
    logic [BW-1:0]   w_bit_cnt_nxt;
    logic [DW-1:0]   r_shift;
    logic [DW-1:0]   w_shift_nxt;
    logic [DW-1:0]   w_shift_sh;
    logic            w_bit_end;

    // The pop side never stalls, so the stall input has no effect.
    logic            w_unused_stall;
    assign w_unused_stall = i_wb_pop_stall;

    assign w_bit_end  = (r_clk_cnt == C_CLK_LAST);
    assign w_shift_sh = r_shift >> 1;

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_stb_nxt     = 1'b0;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt      = 1'b1;
                w_clk_cnt_nxt = '0;
                if (!i_fifo_empty) begin
                    w_state_nxt = S_POP;
                    w_stb_nxt   = 1'b1;
                end
            end

            S_POP: begin
                w_state_nxt = S_WAIT;
            end

            // No ack here means the FIFO refused or ran dry: drop back quietly.
            S_WAIT: begin
                if (i_wb_pop_ack) begin
                    w_shift_nxt   = i_wb_pop_data;
                    w_tx_nxt      = 1'b0;
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_START;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == C_BIT_LAST) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt   = w_shift_sh;
                        w_tx_nxt      = w_shift_sh[0];
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end

            default: begin
                w_tx_nxt      = 1'b1;
                w_clk_cnt_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_stb     <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_stb     <= w_stb_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_wb_pop_stb = r_stb;
    assign o_wb_pop_cyc = (r_state == S_POP) || (r_state == S_WAIT);
    assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/wb_uart_tx_pop.md
# wb_uart_tx_pop

Serial transmitter that drains the FIFO's Wishbone pop bus and shifts each byte out on an 8N1 UART line. It sits directly downstream of the TX FIFO. It issues single-cycle pop strobes whenever the FIFO reports non-empty and it is idle, then captures the acknowledged word. It serialises the word at a fixed integer number of clocks per bit.

## Interface

Parameters:
- `DW`, 8: data word width; frame carries `DW` data bits.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_wb_pop_stb`  out  1  pop request, one cycle wide.
- `o_wb_pop_cyc`  out  1  bus cycle; high during POP and WAIT states.
- `i_wb_pop_stall`  in  1  ignored (pop side never stalls); tie-off tolerated.
- `i_wb_pop_ack`  in  1  pop acknowledge, expected exactly one cycle after strobe.
- `i_wb_pop_data`  in  DW  popped word, valid in the ack cycle.
- `o_tx`  out  1  serial line; idles high.
- `o_busy`  out  1  high whenever state ≠ IDLE.

## Operation

- One clock domain, `i_clk`. Reset is synchronous and active-high on `i_reset`.
- All outputs are registered except `o_busy` and `o_wb_pop_cyc`, which decode the state.
- Reset values:
  - state = IDLE
  - `o_tx` = 1
  - `o_wb_pop_stb` = 0
  - `o_wb_pop_cyc` = 0
  - `o_busy` = 0
  - bit counter = 0
  - clock counter = 0
  - shift register = 0
- States:
  - IDLE: `o_tx` = 1. If `!i_fifo_empty`, go to POP and set `o_wb_pop_stb` = 1 for the next cycle. Otherwise stay in IDLE.
  - POP: strobe is high for exactly this cycle. Always go to WAIT and clear the strobe.
  - WAIT: sample `i_wb_pop_ack`.
    - Ack = 1: load the shift register with `i_wb_pop_data`, drive `o_tx` = 0, clear the clock counter, go to START.
    - Ack = 0: go to IDLE with no transmission. This covers a FIFO that emptied or refused the pop.
  - START: hold `o_tx` = 0 for `CLKS_PER_BIT` cycles. Then drive bit 0 (LSB) and go to DATA with bit counter = 0.
  - DATA: hold each bit for `CLKS_PER_BIT` cycles, then shift right. After bit `DW-1` completes, drive `o_tx` = 1 and go to STOP.
  - STOP: hold `o_tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Clock counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0 .. `CLKS_PER_BIT-1`; the terminal count advances the bit or state.
  - Restarts at 0 on every bit boundary.
- Bit counter: width `$clog2(DW)`, counts 0 .. `DW-1`.
- A strobe is never issued outside IDLE→POP. Therefore strobes are never back-to-back, which satisfies the FIFO's one-cycle-strobe rule.
- `i_fifo_empty` and `i_wb_pop_data` are ignored outside IDLE and WAIT respectively.
- An ack arriving in any state other than WAIT is ignored.

## Timing

- Cycle T: IDLE sees `!i_fifo_empty`.
- Cycle T+1: `o_wb_pop_stb` = 1 (POP).
- Cycle T+2: ack sampled (WAIT).
- Cycle T+3: `o_tx` falls (start bit).
- Frame length is `(DW+2)*CLKS_PER_BIT` cycles from the start-bit edge to the end of the stop bit.
- Back-to-back bytes: the line stays high for the stop bit plus 3 cycles (IDLE, POP, WAIT) before the next start bit.
- Reset at any point, including mid-frame or in POP/WAIT:
  - Next edge gives `o_tx` = 1 and `o_wb_pop_stb` = 0, state IDLE.
  - The in-flight byte is discarded. A pop already acked by the FIFO is lost; this is accepted.
- Reset held for multiple cycles: outputs stay at reset values and no strobe is issued. This holds even if `i_fifo_empty` = 0.
- Simultaneous `!i_fifo_empty` and end of STOP: STOP goes to IDLE first. The strobe follows one cycle later; the line never loses the idle-high gap.

## Test plan

- Reset, then `i_fifo_empty` = 1 for 100 cycles. Required: `o_tx` = 1, `o_busy` = 0, no strobe.
- `CLKS_PER_BIT` = 4, FIFO holds 0xA5:
  - Strobe appears 1 cycle after empty deasserts.
  - Ack follows the strobe by 1 cycle with data 0xA5.
  - `o_tx` sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - Total frame 40 cycles, `o_busy` falls after the stop bit.
- FIFO holds 0x00 then 0xFF, `CLKS_PER_BIT` = 4:
  - Exactly two strobes, never on adjacent cycles.
  - The second start bit falls 4+3 cycles after the first frame's last data bit ends.
  - Serial data matches both bytes, LSB first.
- Strobe issued but `i_wb_pop_ack` withheld:
  - Block returns to IDLE after WAIT with `o_tx` high throughout.
  - With empty still low, a new strobe is issued 1 cycle later.
- `i_reset` pulsed during data bit 3 of 0x5A:
  - `o_tx` = 1 on the next edge, state IDLE, `o_busy` = 0.
  - With the FIFO non-empty, a fresh frame starts normally 3 cycles after reset release.
- `i_wb_pop_ack` pulsed spuriously during DATA and STOP: no effect on the shift register or the serial output.
